uart_rx: RTL and testbench

UART receiver. It is the receive-side counterpart of the team's existing UART transmitter and uses the same frame format: 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1). The line is oversampled by a runtime-selectable prescale. The data bit is decided by a 3-sample majority vote around the bit centre. The block checks start, parity and stop bits and presents the byte with a one-cycle valid pulse to the system side of the multi-clock design, in the UART clock domain.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/data_sampling.sv | 68 ++++++
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - receiver FSM state encoding
//   - legal oversampling ratios (8/16/32)
//   - parity type constants, same meaning as the transmitter's parity_calc
//   - 3-input majority helper used by the receive sampler
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_OUT    = 3'd5
  } uart_rx_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Majority of three line samples; masks a single-sample glitch.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/data_sampling.sv
// ---------------------------------------------------------------------------
// data_sampling
// Takes three samples of the serial line around the bit centre
// (edge_cnt = P/2-1, P/2, P/2+1) and registers their majority.
// Ports:
//   clk, rst      UART oversampling clock, async active-low reset
//   rx_in         serial line (already synchronised)
//   edge_cnt      position inside the current bit, 0..P-1
//   prescale      latched oversampling ratio P for the current frame
//   sampled_bit   majority-voted bit, valid from edge_cnt = P/2+2
//   sample_done   1-clk pulse while edge_cnt = P/2+2 (new sampled_bit)
// ---------------------------------------------------------------------------
module data_sampling
  import uart_pkg::*;
#(
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic [PRESC_WIDTH-1:0] edge_cnt,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   sampled_bit,
  output logic                   sample_done
);

  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic [PRESC_WIDTH-1:0] half_s;
  logic [PRESC_WIDTH-1:0] first_s;
  logic [PRESC_WIDTH-1:0] last_s;
  logic                   smp0_r;
  logic                   smp1_r;
  logic                   bit_r;
  logic                   done_r;

  // Sample positions around the bit centre, unsigned at PRESC_WIDTH.
  always_comb begin
    half_s  = {1'b0, prescale[PRESC_WIDTH-1:1]};
    first_s = half_s - PRESC_ONE;
    last_s  = half_s + PRESC_ONE;
  end

  // Capture the first two samples; the third is voted directly from rx_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp0_r <= 1'b0;
      smp1_r <= 1'b0;
      bit_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (edge_cnt == last_s);
      if (edge_cnt == first_s) begin
        smp0_r <= rx_in;
      end else if (edge_cnt == half_s) begin
        smp1_r <= rx_in;
      end else if (edge_cnt == last_s) begin
        bit_r <= majority3(smp0_r, smp1_r, rx_in);
      end else begin
        bit_r <= bit_r;
      end
    end
  end

  assign sampled_bit = bit_r;
  assign sample_done = done_r;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity
// bit, one stop bit. Oversampled by a prescale latched at frame start.
// Ports:
//   clk, rst    UART oversampling clock, async active-low reset
//   rx_in       serial line, idle high, already synchronised
//   prescale    oversampling ratio; 8/16/32, anything else behaves as 8
//   par_en      parity bit present in the frame
//   par_typ     0 = even parity, 1 = odd parity
//   p_data      last correctly received byte
//   data_valid  1-clk pulse when p_data is updated
//   par_err     1-clk pulse, parity mismatch in the frame just ended
//   stp_err     1-clk pulse, stop bit sampled as 0
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  output logic [DATA_WIDTH-1:0]  p_data,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stp_err
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [PRESC_WIDTH-1:0] P8        = PRESC_WIDTH'(PRESC_8);
  localparam logic [PRESC_WIDTH-1:0] P16       = PRESC_WIDTH'(PRESC_16);
  localparam logic [PRESC_WIDTH-1:0] P32       = PRESC_WIDTH'(PRESC_32);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] EDGE_ZERO = {PRESC_WIDTH{1'b0}};
  localparam logic [BIT_CNT_W-1:0]   BIT_ZERO  = {BIT_CNT_W{1'b0}};
  localparam logic [BIT_CNT_W-1:0]   BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_rx_state_e         state_r;
  logic [PRESC_WIDTH-1:0] edge_cnt_r;
  logic [PRESC_WIDTH-1:0] presc_r;
  logic [PRESC_WIDTH-1:0] presc_legal_s;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic [DATA_WIDTH-1:0]  p_data_r;
  logic                   par_en_r;
  logic                   par_typ_r;
  logic                   par_flag_r;
  logic                   data_valid_r;
  logic                   par_err_r;
  logic                   stp_err_r;
  logic                   sampled_bit_s;
  logic                   sample_done_s;
  logic                   bit_end_s;
  logic                   par_exp_s;

  data_sampling #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_data_sampling (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .edge_cnt    (edge_cnt_r),
    .prescale    (presc_r),
    .sampled_bit (sampled_bit_s),
    .sample_done (sample_done_s)
  );

  // Map the raw prescale input onto one of the legal ratios.
  always_comb begin
    if (prescale == P16) begin
      presc_legal_s = P16;
    end else if (prescale == P32) begin
      presc_legal_s = P32;
    end else begin
      presc_legal_s = P8;
    end
  end

  // Last oversampling clock of the current bit.
  always_comb begin
    bit_end_s = (edge_cnt_r == (presc_r - PRESC_ONE));
  end

  // Expected parity bit for the received data under the latched parity type.
  always_comb begin
    case (par_typ_r)
      PAR_EVEN: par_exp_s = ^shift_r;
      PAR_ODD:  par_exp_s = ~(^shift_r);
      default:  par_exp_s = ^shift_r;
    endcase
  end

  // Receive FSM with bit/edge counters, shift register and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      edge_cnt_r   <= EDGE_ZERO;
      bit_cnt_r    <= BIT_ZERO;
      shift_r      <= {DATA_WIDTH{1'b0}};
      p_data_r     <= {DATA_WIDTH{1'b0}};
      presc_r      <= P8;
      par_en_r     <= 1'b0;
      par_typ_r    <= PAR_EVEN;
      par_flag_r   <= 1'b0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
    end else begin
      // Result outputs are pulses: they are only raised on the STOP->OUT edge.
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;

      if ((state_r == ST_IDLE) || (state_r == ST_OUT)) begin
        edge_cnt_r <= EDGE_ZERO;
      end else if (bit_end_s) begin
        edge_cnt_r <= EDGE_ZERO;
      end else begin
        edge_cnt_r <= edge_cnt_r + PRESC_ONE;
      end

      case (state_r)
        ST_IDLE: begin
          if (!rx_in) begin
            state_r    <= ST_START;
            presc_r    <= presc_legal_s;
            par_en_r   <= par_en;
            par_typ_r  <= par_typ;
            bit_cnt_r  <= BIT_ZERO;
            par_flag_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          // A start bit that votes high was a glitch: drop it silently.
          if (bit_end_s) begin
            state_r <= sampled_bit_s ? ST_IDLE : ST_DATA;
          end else begin
            state_r <= ST_START;
          end
        end
        ST_DATA: begin
          if (sample_done_s) begin
            shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
          end else begin
            shift_r <= shift_r;
          end
          if (bit_end_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= BIT_ZERO;
              state_r   <= par_en_r ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        ST_PARITY: begin
          if (sample_done_s) begin
            par_flag_r <= (sampled_bit_s != par_exp_s);
          end else begin
            par_flag_r <= par_flag_r;
          end
          if (bit_end_s) begin
            state_r <= ST_STOP;
          end else begin
            state_r <= ST_PARITY;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            state_r   <= ST_OUT;
            par_err_r <= par_flag_r;
            stp_err_r <= ~sampled_bit_s;
            if (!par_flag_r && sampled_bit_s) begin
              p_data_r     <= shift_r;
              data_valid_r <= 1'b1;
            end else begin
              p_data_r <= p_data_r;
            end
          end else begin
            state_r <= ST_STOP;
          end
        end
        ST_OUT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign p_data     = p_data_r;
  assign data_valid = data_valid_r;
  assign par_err    = par_err_r;
  assign stp_err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames into uart_rx. Each frame pushes its expected result
// (flags, p_data, clock index of the pulse) into a queue; a monitor pops and
// compares whenever the receiver raises data_valid, par_err or stp_err.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  exp_t       sb_q[$];
  longint     cyc       = 0;
  longint     ready_cyc = 0;   // first clock index at which the receiver watches the line
  logic [7:0] last_good = 8'h00;
  int         checks    = 0;
  int         errors    = 0;

  uart_rx #(
    .DATA_WIDTH  (8),
    .PRESC_WIDTH (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  // Clock index: value k is visible after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int frame_p(input logic [5:0] p);
    if (p == 6'd16) return 16;
    else if (p == 6'd32) return 32;
    else return 8;
  endfunction

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame; called at a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic [5:0] presc, input logic pe,
                            input logic pt, input bit bad_par, input bit bad_stop,
                            input bit b2b, input bit scramble);
    int     p;
    int     ones;
    longint det;
    logic   pb;
    logic   bits[$];
    exp_t   e;
    p        = frame_p(presc);
    prescale = presc;
    par_en   = pe;
    par_typ  = pt;
    // Start is seen on the next rising edge, unless the receiver is still
    // finishing the previous frame (OUT cycle plus re-arm).
    det = cyc + 1;
    if (b2b || (det < ready_cyc)) det = ready_cyc;
    ones = $countones(d);
    // Parity bit makes the total count of ones even (pt=0) or odd (pt=1).
    pb = ((ones % 2) == 1) ? ~pt : pt;
    if (bad_par) pb = ~pb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(bad_stop ? 1'b0 : 1'b1);
    e.pe = pe && bad_par;
    e.se = bad_stop;
    e.dv = !e.pe && !e.se;
    if (e.dv) last_good = d;
    e.data = last_good;
    e.cyc  = det + longint'(bits.size() * p);
    sb_q.push_back(e);
    ready_cyc = e.cyc + 2;
    foreach (bits[i]) begin
      rx_in = bits[i];
      if (scramble && (i == 1)) begin
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom_range(0, 1));
        par_typ  = 1'($urandom_range(0, 1));
      end
      repeat (p) @(negedge clk);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        while ((sb_q.size() > 0) && (sb_q[0].cyc < cyc)) begin
          e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_pulse: no output seen, required at cycle %0d (now %0d)", e.cyc, cyc);
        end
        if ((data_valid !== 1'b0) || (par_err !== 1'b0) || (stp_err !== 1'b0)) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b at cycle %0d, required none",
                     data_valid, par_err, stp_err, cyc);
          end else begin
            e = sb_q.pop_front();
            check("data_valid", 64'(data_valid), 64'(e.dv));
            check("par_err", 64'(par_err), 64'(e.pe));
            check("stp_err", 64'(stp_err), 64'(e.se));
            check("p_data", 64'(p_data), 64'(e.data));
            check("pulse_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rp;
    bit         b2b;
    bit         prev_b2b;
    bit         pe_r;
    longint     det;

    rst      = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", 64'(p_data), 64'h0);
    check("reset_data_valid", 64'(data_valid), 64'h0);
    check("reset_par_err", 64'(par_err), 64'h0);
    check("reset_stp_err", 64'(stp_err), 64'h0);
    rst = 1'b1;
    ready_cyc = cyc + 1;
    idle(5);

    // 0xA5, P=8, even parity: pulse 88 clk after start is seen.
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    // 0x3C, P=16, odd parity, wrong parity bit: par_err, p_data stays 0xA5.
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // 0x81, P=32, no parity, stop bit 0; then a good 0x7E.
    send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    send_frame(8'h7E, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Start glitch: 3 clk low at P=8, then idle; nothing may pulse.
    prescale = 6'd8;
    par_en   = 1'b0;
    det      = cyc + 1;
    rx_in    = 1'b0;
    repeat (3) @(negedge clk);
    ready_cyc = det + 8 + 1;
    idle(20);
    check("glitch_p_data", 64'(p_data), 64'(last_good));

    // Back-to-back 0x55 then 0xAA, P=8, no idle gap on the line.
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hAA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);

    // Line stuck low for three frame periods: one stp_err per frame, no lockup.
    prescale = 6'd8;
    par_en   = 1'b0;
    det      = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.dv   = 1'b0;
      e.pe   = 1'b0;
      e.se   = 1'b1;
      e.data = last_good;
      e.cyc  = det + 80;
      sb_q.push_back(e);
      det = det + 82;
    end
    ready_cyc = det;
    rx_in = 1'b0;
    repeat (244) @(negedge clk);
    idle(12);

    // Reset in the middle of the data bits of 0xF0.
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i >= 4) ? 1'b1 : 1'b0;
      repeat (8) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("midreset_p_data", 64'(p_data), 64'h0);
    check("midreset_data_valid", 64'(data_valid), 64'h0);
    check("midreset_par_err", 64'(par_err), 64'h0);
    check("midreset_stp_err", 64'(stp_err), 64'h0);
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ready_cyc = cyc + 1;
    idle(4);
    send_frame(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised frames: prescale (legal and illegal), parity, injected errors,
    // mid-frame configuration changes, occasional back-to-back frames.
    prev_b2b = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rp = 6'd8;
        1: rp = 6'd16;
        2: rp = 6'd32;
        default: begin
          do rp = 6'($urandom_range(0, 63)); while ((rp == 6'd8) || (rp == 6'd16) || (rp == 6'd32));
        end
      endcase
      b2b  = !prev_b2b && ($urandom_range(0, 3) == 0);
      pe_r = 1'($urandom_range(0, 1));
      if (!b2b) idle($urandom_range(4, 12));
      send_frame(8'($urandom_range(0, 255)), rp, pe_r, 1'($urandom_range(0, 1)),
                 pe_r && ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 b2b, ($urandom_range(0, 2) == 0));
      prev_b2b = b2b;
    end
    idle(4);

    for (int k = 0; (k < 500) && (sb_q.size() > 0); k++) @(negedge clk);
    check("queue_drained", 64'(sb_q.size()), 64'h0);
    check("final_p_data", 64'(p_data), 64'(last_good));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
